// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants and the multiplier FSM state encoding.
package secp256k1_pkg;

  localparam int unsigned WIDTH = 256;
  localparam logic [WIDTH-1:0] PRIME =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_add_reduce.sv
// Combinational (x + y) mod PRIME for x, y < PRIME: one add, one conditional subtract.
module mod_add_reduce #(
  parameter int unsigned      WIDTH = secp256k1_pkg::WIDTH,
  parameter logic [WIDTH-1:0] PRIME = secp256k1_pkg::PRIME
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum_c
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] d;

  // Full-width sum with carry, then subtract PRIME once if the sum reaches it.
  always_comb begin
    s     = {1'b0, x} + {1'b0, y};
    d     = s - {1'b0, PRIME};
    sum_c = (s >= {1'b0, PRIME}) ? d[WIDTH-1:0] : s[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential a*b mod PRIME, MSB-first interleaved double-and-add, one multiplier bit per clock.
module mod_mul_seq
  import secp256k1_pkg::*;
#(
  parameter int unsigned      WIDTH = secp256k1_pkg::WIDTH,
  parameter logic [WIDTH-1:0] PRIME = secp256k1_pkg::PRIME
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [WIDTH-1:0] a_reg, a_d;
  logic [WIDTH-1:0] b_reg, b_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] product_d;
  logic [WIDTH-1:0] dbl_c, add_c, step_c;

  // Doubling stage: 2*acc mod PRIME.
  mod_add_reduce #(.WIDTH(WIDTH), .PRIME(PRIME)) u_dbl (
    .x     (acc),
    .y     (acc),
    .sum_c (dbl_c)
  );

  // Conditional-add stage: (2*acc + a) mod PRIME.
  mod_add_reduce #(.WIDTH(WIDTH), .PRIME(PRIME)) u_add (
    .x     (dbl_c),
    .y     (a_reg),
    .sum_c (add_c)
  );

  // Select the next accumulator from the current multiplier bit.
  always_comb begin
    step_c = b_reg[cnt] ? add_c : dbl_c;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    a_d       = a_reg;
    b_d       = b_reg;
    cnt_d     = cnt;
    busy_d    = busy;
    done_d    = 1'b0;
    product_d = product;
    case (state)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_c;
        cnt_d = cnt - CNT_W'(1);
        if (cnt == '0) begin
          product_d = step_c;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      a_reg   <= a_d;
      b_reg   <= b_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      product <= product_d;
    end
  end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Self-checking bench for mod_mul_seq: directed vectors, handshake corners, random vs. big-integer model.
module tb_mod_mul_seq;

  localparam logic [255:0] P =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] X =
    256'hA3F9D2B8C6A1F4E2B3A7D1E4F123CB98A1234567890ABCDEFA1234567890F12;
  localparam logic [255:0] Y =
    256'h9A3F2D7C8B1E6F4A5C9D2E0F8A7B1C2D3E8F9A123456789ABCDEF0123456789;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] a_in, b_in;
  logic         busy, done;
  logic [255:0] product;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[6];

  mod_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Reference: exact product through 512-bit integer arithmetic.
  function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] w;
    w = (512'(x) * 512'(y)) % 512'(P);
    return w[255:0];
  endfunction

  // Reference for the upstream subtractor: (x - y) mod p.
  function automatic logic [255:0] ref_sub(input logic [255:0] x, input logic [255:0] y);
    logic [256:0] w;
    w = (257'(x) + 257'(P) - 257'(y)) % 257'(P);
    return w[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v % P;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One full operation with latency, busy, done-width and product checks.
  task automatic do_mul(input string name, input logic [255:0] x, input logic [255:0] y,
                        input logic [255:0] exp, input bit chk_prod);
    int cyc;
    int busy_bad;
    @(negedge clk);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 256'(cyc), 256'd257);
    chk({name, " busy during run"}, 256'(busy_bad), 256'd0);
    chk({name, " busy at done"}, 256'(busy), 256'd0);
    if (chk_prod) chk({name, " product"}, product, exp);
    @(negedge clk);
    chk({name, " done width"}, 256'(done), 256'd0);
    if (chk_prod) chk({name, " product hold"}, product, exp);
  endtask

  initial begin
    logic [255:0] ra, rb, d, exp1;
    int dcnt, dcyc;

    vecs[0] = '{a: 256'd3, b: 256'd5, exp: 256'd15};
    vecs[1] = '{a: P - 256'd1, b: P - 256'd1, exp: 256'd1};
    vecs[2] = '{a: P - 256'd1, b: 256'd2,
                exp: 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D};
    vecs[3] = '{a: 256'd0, b: Y, exp: 256'd0};
    vecs[4] = '{a: X, b: 256'd1, exp: X};
    vecs[5] = '{a: 256'd1, b: X, exp: X};

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 256'(busy), 256'd0);
    chk("reset done", 256'(done), 256'd0);
    chk("reset product", product, 256'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);

    // Chained from the subtractor, both without and with wraparound.
    d = ref_sub(X, Y);
    do_mul("chain x-y", d, 256'd2, ref_mul(d, 256'd2), 1'b1);
    d = ref_sub(Y, X);
    do_mul("chain y-x", d, 256'd2, ref_mul(d, 256'd2), 1'b1);

    for (int i = 0; i < 8; i++) begin
      ra = rand_fe();
      rb = rand_fe();
      do_mul($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), 1'b1);
    end

    // Out-of-contract operands must still complete on time.
    do_mul("ooc", '1, '1, 256'd0, 1'b0);

    // Start re-asserted mid-run, on the last busy cycle and on the done cycle.
    exp1 = ref_mul(X, Y);
    @(negedge clk);
    a_in  = X;
    b_in  = Y;
    start = 1'b1;
    dcnt  = 0;
    dcyc  = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcnt++;
        dcyc = cyc;
        chk("ignore product at done", product, exp1);
      end
      start = (cyc == 10 || cyc == 256 || cyc == 257);
      a_in  = 256'd7;
      b_in  = 256'd11;
    end
    start = 1'b0;
    chk("ignore done count", 256'(dcnt), 256'd1);
    chk("ignore done cycle", 256'(dcyc), 256'd257);
    chk("ignore product held", product, exp1);
    chk("ignore not restarted", 256'(busy), 256'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a_in  = Y;
    b_in  = X;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 100; cyc++) @(negedge clk);
    chk("pre-reset busy", 256'(busy), 256'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 256'(busy), 256'd0);
    chk("async reset done", 256'(done), 256'd0);
    chk("async reset product", product, 256'd0);
    dcnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 3) reset = 1'b0;
      if (done === 1'b1) dcnt++;
    end
    chk("aborted run no done", 256'(dcnt), 256'd0);
    do_mul("after reset", X, Y, exp1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_mul_seq.md
Name: mod_mul_seq

Overview:
- Sequential modular multiplier over the secp256k1 field prime p = 2^256 - 2^32 - 977.
- Directly downstream of mod_sub in the point-arithmetic datapath. It consumes mod_sub's 256-bit difference, e.g. (y2 - y1) times an inverse, or (x1 - x3) times lambda, and returns a*b mod p.
- Uses MSB-first interleaved double-and-add: one multiplier bit per clock, with a start/busy/done handshake.

Parameters:
- WIDTH, 256, operand and result width in bits.
- PRIME, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field modulus.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request a multiplication; sampled only in IDLE.
- a  input  WIDTH  multiplicand; must be < PRIME.
- b  input  WIDTH  multiplier; must be < PRIME.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is valid.
- product  output  WIDTH  a*b mod PRIME; held stable until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, product=0, state=IDLE, counter=0, internal acc/a_reg/b_reg=0. An asserted reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge:
  - a_reg<=a, b_reg<=b, acc<=0, cnt<=WIDTH-1, state<=RUN.
  - busy becomes 1 in the next cycle.
  - product keeps its old value.
- RUN, one iteration per edge:
  - t = (2*acc) mod p.
  - acc <= b_reg[cnt] ? (t + a_reg) mod p : t.
  - cnt decrements.
  - On the edge where cnt==0: acc and product get the final value, state<=DONE.
- DONE: done=1 and busy=0 for exactly one cycle, with product valid. The state then returns to IDLE.
- Latency: start sampled at edge k gives done high during the cycle after edge k+256, i.e. 257 cycles from start to done. Throughput is one operation per 258 cycles.
- start while busy or in DONE is ignored, not queued. start in the same cycle done is high is also ignored. A new start is accepted the cycle after done.
- Arithmetic rule for each mod-add step:
  - Form the 257-bit sum s.
  - If s >= PRIME, the result is s - PRIME, else s.
  - Inputs < PRIME guarantee the result is < PRIME after a single conditional subtract.
- Operands >= PRIME are out of contract; the result is unspecified but must not hang the FSM. It still completes in 257 cycles.
- Doubling 2*acc uses the same add-reduce with both inputs equal to acc.

Decomposition:
- Shared package secp256k1_pkg holds:
  - WIDTH and PRIME constants (also reused by mod_sub and the future mod_inv).
  - The state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, mod_add_reduce: combinational (x + y) mod PRIME for x, y < PRIME. It is instanced twice (double stage and conditional-add stage).
- The top level holds the FSM, counter and registers only.

Test Plan:
- a=3, b=5, one start pulse -> done pulses exactly 257 cycles later, product=15, busy high for cycles 1..256.
- a=p-1, b=p-1 -> product=1. Then a=p-1, b=2 -> product=p-2 = ...FFFFFC2D.
- a=0, b=any, and a=x, b=1 with x = 256'hA3F9D2B8C6A1F4E2B3A7D1E4F123CB98A1234567890ABCDEFA1234567890F12 -> product=0 and product=x respectively.
- Chained: feed the mod_sub difference of x and y=256'h9A3F2D7C8B1E6F4A5C9D2E0F8A7B1C2D3E8F9A123456789ABCDEF0123456789 as a, with b=2 -> product equals mod_sub(x,y)*2 mod p, checked against a reference model.
- start re-asserted at cycles 10 and 256 of a run, with different operands -> ignored; first result correct; exactly one done pulse; product unchanged until the next accepted start.
- reset asserted at cycle 100 of a run -> busy, done and product go to 0 immediately (asynchronously); no done pulse. A fresh start afterwards yields the correct product.
